// File: rtl/nor_gate_demux.sv
// Purpose : bitwise 2-input NOR built from per-lane 1:4 demuxes (data tied high, sel = {a,b}), registered.
// Latency : 1 core clock from the capturing edge (in_valid high) to nor_o/minterm_o/onehot_err/out_valid.
// Backpressure: none; accepts one sample per clock whenever in_valid is high, results are never stalled.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears all outputs
//   in_valid   qualifies a/b; outputs only update on edges where it is high
//   a, b       per-lane operands (WIDTH lanes)
//   nor_o      registered NOR per lane, taken from demux output y0
//   minterm_o  registered demux outputs, lane i at [4i+3:4i], bit 4i+k set when {a[i],b[i]} == k
//   out_valid  one-cycle pulse per captured sample
//   onehot_err registered self-check: some lane's demux outputs were not exactly one-hot

module demux_1to4 (
    input  logic       din,
    input  logic [1:0] sel,
    output logic [3:0] y
);
    // Each output passes din only when sel addresses it.
    assign y[0] = din & ~sel[1] & ~sel[0];
    assign y[1] = din & ~sel[1] &  sel[0];
    assign y[2] = din &  sel[1] & ~sel[0];
    assign y[3] = din &  sel[1] &  sel[0];
endmodule

module nor_gate_demux #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [WIDTH-1:0]     nor_o,
    output logic [4*WIDTH-1:0]   minterm_o,
    output logic                 out_valid,
    output logic                 onehot_err
);

    logic [4*WIDTH-1:0] demux_y;
    logic [WIDTH-1:0]   nor_nxt;
    logic               err_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        // Data input tied high: the demux turns the 2-bit select into the
        // four minterms of (a,b), so y0 is exactly the NOR of the lane.
        demux_1to4 u_demux (
            .din (1'b1),
            .sel ({a[i], b[i]}),
            .y   (demux_y[4*i +: 4])
        );
    end

    always_comb begin
        nor_nxt = '0;
        err_nxt = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            nor_nxt[i] = demux_y[4*i];
            // A healthy demux with a driven data input selects exactly one output.
            if ($countones(demux_y[4*i +: 4]) != 1) begin
                err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nor_o      <= '0;
            minterm_o  <= '0;
            out_valid  <= 1'b0;
            onehot_err <= 1'b0;
        end else begin
            out_valid <= in_valid;
            // Data registers hold their last captured sample when in_valid is low.
            if (in_valid) begin
                nor_o      <= nor_nxt;
                minterm_o  <= demux_y;
                onehot_err <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_nor_gate_demux.sv
module tb_nor_gate_demux;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        a1, b1;
    logic [3:0]  a4, b4;
    logic        nor1;
    logic [3:0]  mint1;
    logic        vld1, err1;
    logic [3:0]  nor4;
    logic [15:0] mint4;
    logic        vld4, err4;

    nor_gate_demux #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a1),
        .b          (b1),
        .nor_o      (nor1),
        .minterm_o  (mint1),
        .out_valid  (vld1),
        .onehot_err (err1)
    );

    nor_gate_demux #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a4),
        .b          (b4),
        .nor_o      (nor4),
        .minterm_o  (mint4),
        .out_valid  (vld4),
        .onehot_err (err4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state: what the outputs should show right now.
    logic        e_nor1;
    logic [3:0]  e_mint1;
    logic [3:0]  e_nor4;
    logic [15:0] e_mint4;
    logic        e_vld;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // One-hot minterm vector per lane: bit (4*lane + 2*a + b) set.
    function automatic logic [15:0] minterms(input logic [3:0] a, input logic [3:0] b, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[4*i + 2*int'(a[i]) + int'(b[i])] = 1'b1;
        end
        return r;
    endfunction

    task automatic model_reset();
        e_nor1  = 1'b0;
        e_mint1 = '0;
        e_nor4  = '0;
        e_mint4 = '0;
        e_vld   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_nor1"},  16'(nor1),  16'(e_nor1));
        check({tag, "_mint1"}, 16'(mint1), 16'(e_mint1));
        check({tag, "_vld1"},  16'(vld1),  16'(e_vld));
        check({tag, "_err1"},  16'(err1),  16'(0));
        check({tag, "_nor4"},  16'(nor4),  16'(e_nor4));
        check({tag, "_mint4"}, mint4,      e_mint4);
        check({tag, "_vld4"},  16'(vld4),  16'(e_vld));
        check({tag, "_err4"},  16'(err4),  16'(0));
    endtask

    // Advance one clock, update the model from the inputs seen at the edge,
    // then compare shortly after the edge.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) begin
            if (in_valid) begin
                e_nor1  = ~(a1 | b1);
                e_mint1 = 4'(minterms({3'b000, a1}, {3'b000, b1}, 1));
                e_nor4  = ~(a4 | b4);
                e_mint4 = minterms(a4, b4, 4);
            end
            e_vld = in_valid;
        end
        #1;
        check_all(tag);
    endtask

    logic [1:0] tt_ab   [7] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    logic       tt_nor  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] tt_mint [7] = '{4'b1000, 4'b0100, 4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0100};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;
        model_reset();
        #2;
        check_all("por");
        tick("in_rst");
        #1;
        rst_n = 1'b1;

        // Test 1: asynchronous reset mid-cycle with nor_o previously 1.
        a1 = 1'b0; b1 = 1'b0; a4 = 4'b0000; b4 = 4'b0000; in_valid = 1'b1;
        tick("pre_rst");
        check("pre_rst_nor1_one", 16'(nor1), 16'(1));
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        tick("rst_held");

        // Test 6: release reset mid-cycle; first edge captures normally.
        #2;
        rst_n = 1'b1;
        a1 = 1'b0; b1 = 1'b0; in_valid = 1'b1;
        tick("rst_release");
        check("rel_nor1", 16'(nor1), 16'(1));
        check("rel_vld1", 16'(vld1), 16'(1));

        // Test 2: truth table sequence on the single-lane instance.
        for (int k = 0; k < 7; k++) begin
            a1 = tt_ab[k][1]; b1 = tt_ab[k][0]; in_valid = 1'b1;
            tick("tt");
            check("tt_nor_tbl",  16'(nor1),  16'(tt_nor[k]));
            check("tt_mint_tbl", 16'(mint1), 16'(tt_mint[k]));
            check("tt_vld_tbl",  16'(vld1),  16'(1));
        end

        // Test 3: hold behaviour while in_valid is low.
        a1 = 1'b0; b1 = 1'b0; in_valid = 1'b1;
        tick("hold_load");
        a1 = 1'b1; b1 = 1'b1; in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick("hold");
            check("hold_nor1", 16'(nor1), 16'(1));
            check("hold_vld1", 16'(vld1), 16'(0));
        end
        in_valid = 1'b1;
        tick("hold_release");
        check("hold_release_nor1", 16'(nor1), 16'(0));

        // Test 4: multi-lane fixed vector.
        a4 = 4'b1100; b4 = 4'b1010; in_valid = 1'b1;
        tick("ml");
        check("ml_nor4",  16'(nor4), 16'(4'b0001));
        check("ml_mint4", mint4,     16'b1000_0100_0010_0001);

        // Test 5: random back-to-back samples.
        for (int k = 0; k < 1000; k++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom);
            in_valid = 1'b1;
            tick("rnd");
        end

        // Random samples with gaps in in_valid.
        for (int k = 0; k < 300; k++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            a4 = 4'($urandom); b4 = 4'($urandom);
            in_valid = 1'($urandom_range(0, 1));
            tick("rnd_gap");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
